// File: rtl/dual2_wide_wr_narrow_rd.sv
// dual2_wide_wr_narrow_rd: self-test of a 32-bit-write / 16-bit-read dual-port memory with counting pattern
module dual2_wide_wr_narrow_rd #(
  parameter int          WR_DEPTH     = 512,
  parameter logic [15:0] PATTERN_BASE = 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_w,
  input  logic        start_r,
  output logic [15:0] data_out,
  output logic [9:0]  rd_addr,
  output logic        data_valid,
  output logic        busy_w,
  output logic        busy_r,
  output logic        done_w,
  output logic        done_r
);
  localparam int WAW = $clog2(WR_DEPTH);
  localparam int RAW = WAW + 1;
  typedef enum logic [1:0] {W_IDLE, W_RUN, W_DONE} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_RUN, R_DONE} r_state_t;
  logic [31:0]    mem [WR_DEPTH];
  w_state_t       w_state_q, w_state_d;
  r_state_t       r_state_q, r_state_d;
  logic [WAW-1:0] wcnt_q, wcnt_d;
  logic [RAW-1:0] rcnt_q, rcnt_d;
  logic           we;
  logic [15:0]    wr_lo;
  logic [31:0]    rd_word;
  logic [15:0]    data_d;
  logic [9:0]     addr_d;
  logic           valid_d, done_r_d;
  assign wr_lo   = PATTERN_BASE + (16'(wcnt_q) << 1);
  assign rd_word = mem[rcnt_q[RAW-1:1]];
  assign busy_w  = w_state_q != W_IDLE;
  assign busy_r  = r_state_q != R_IDLE;
  assign done_w  = w_state_q == W_DONE;
  // write sequencer: one word per cycle, then a single done cycle
  always_comb begin
    w_state_d = w_state_q;
    wcnt_d    = wcnt_q;
    we        = 1'b0;
    case (w_state_q)
      W_IDLE: if (start_w) begin
        w_state_d = W_RUN;
        wcnt_d    = '0;
      end
      W_RUN: begin
        we        = 1'b1;
        w_state_d = (wcnt_q == WAW'(WR_DEPTH - 1)) ? W_DONE : W_RUN;
        wcnt_d    = (wcnt_q == WAW'(WR_DEPTH - 1)) ? wcnt_q : wcnt_q + 1'b1;
      end
      default: w_state_d = W_IDLE;
    endcase
  end
  // read sequencer: one narrow beat per cycle, low half of each word first
  always_comb begin
    r_state_d = r_state_q;
    rcnt_d    = rcnt_q;
    data_d    = data_out;
    addr_d    = rd_addr;
    valid_d   = 1'b0;
    done_r_d  = 1'b0;
    case (r_state_q)
      R_IDLE: if (start_r) begin
        r_state_d = R_RUN;
        rcnt_d    = '0;
      end
      R_RUN: begin
        valid_d   = 1'b1;
        addr_d    = 10'(rcnt_q);
        data_d    = rcnt_q[0] ? rd_word[31:16] : rd_word[15:0];
        r_state_d = (rcnt_q == RAW'(2 * WR_DEPTH - 1)) ? R_DONE : R_RUN;
        rcnt_d    = (rcnt_q == RAW'(2 * WR_DEPTH - 1)) ? rcnt_q : rcnt_q + 1'b1;
      end
      R_DONE: begin
        done_r_d  = 1'b1;
        r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end
  // state, counters and registered read outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      data_out   <= '0;
      rd_addr    <= '0;
      data_valid <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      data_out   <= data_d;
      rd_addr    <= addr_d;
      data_valid <= valid_d;
      done_r     <= done_r_d;
    end
  end
  // memory write port; contents survive reset, reads see pre-write data
  always_ff @(posedge clk) begin
    if (we) mem[wcnt_q] <= {wr_lo + 16'd1, wr_lo};
  end
endmodule

// File: tb/tb_dual2_wide_wr_narrow_rd.sv
// tb_dual2_wide_wr_narrow_rd: scoreboard and table checks for the asymmetric memory self-test
module tb_dual2_wide_wr_narrow_rd;
  localparam int PERIOD_W = 514;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  start_w = '0, start_r = '0;
  logic [1:0]  valid, busy_w, busy_r, done_w, done_r;
  logic [15:0] dout [2];
  logic [9:0]  raddr [2];
  logic [25:0] q0 [$];
  logic [25:0] q1 [$];
  logic [15:0] cap0 [1024];
  logic [15:0] cap1 [1024];
  int applied = 0, miscompares = 0, cyc = 0;
  int beats [2] = '{0, 0};
  int last_cyc [2] = '{0, 0};
  int done_r_cyc [2] = '{0, 0};
  int done_r_cnt [2] = '{0, 0};
  int done_w_cnt [2] = '{0, 0};
  typedef struct {int inst; int n; logic [15:0] exp;} vec_t;
  vec_t vt [10];

  dual2_wide_wr_narrow_rd dut0 (
    .clk(clk), .rst(rst), .start_w(start_w[0]), .start_r(start_r[0]),
    .data_out(dout[0]), .rd_addr(raddr[0]), .data_valid(valid[0]),
    .busy_w(busy_w[0]), .busy_r(busy_r[0]), .done_w(done_w[0]), .done_r(done_r[0])
  );
  dual2_wide_wr_narrow_rd #(.PATTERN_BASE(16'hFFFE)) dut1 (
    .clk(clk), .rst(rst), .start_w(start_w[1]), .start_r(start_r[1]),
    .data_out(dout[1]), .rd_addr(raddr[1]), .data_valid(valid[1]),
    .busy_w(busy_w[1]), .busy_r(busy_r[1]), .done_w(done_w[1]), .done_r(done_r[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // monitor: every valid beat is popped against the scoreboard
  always @(negedge clk) begin
    logic [25:0] e;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (done_r[i]) begin
        done_r_cnt[i]++;
        done_r_cyc[i] = cyc;
      end
      if (done_w[i]) done_w_cnt[i]++;
      if (valid[i]) begin
        beats[i]++;
        last_cyc[i] = cyc;
        if (i == 0) cap0[raddr[0]] = dout[0];
        else cap1[raddr[1]] = dout[1];
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
          chk("unexpected_beat", {6'd0, raddr[i], dout[i]}, 32'hFFFF_FFFF);
        end else begin
          if (i == 0) e = q0.pop_front();
          else e = q1.pop_front();
          chk(i == 0 ? "beat0" : "beat1", {6'd0, raddr[i], dout[i]}, {6'd0, e});
        end
      end
    end
  end

  task automatic push_exp(input int i);
    for (int n = 0; n < 1024; n++) begin
      if (i == 0) q0.push_back({10'(n), 16'd1 + 16'(n)});
      else q1.push_back({10'(n), 16'hFFFE + 16'(n)});
    end
  endtask

  task automatic run_write(input int i);
    int n = 0;
    int d0 = done_w_cnt[i];
    start_w[i] = 1'b1;
    tick();
    start_w[i] = 1'b0;
    while (busy_w[i] && n < 2000) begin
      n++;
      tick();
    end
    chk("busy_w_len", n, 513);
    chk("done_w_pulses", done_w_cnt[i] - d0, 1);
  endtask

  task automatic run_read(input int i);
    int n = 0;
    int b0 = beats[i];
    int d0 = done_r_cnt[i];
    push_exp(i);
    start_r[i] = 1'b1;
    tick();
    start_r[i] = 1'b0;
    while (done_r_cnt[i] == d0 && n < 1200) begin
      n++;
      tick();
    end
    repeat (4) tick();
    chk("read_beats", beats[i] - b0, 1024);
    chk("done_r_pulses", done_r_cnt[i] - d0, 1);
    chk("done_r_after_last", done_r_cyc[i], last_cyc[i] + 1);
    chk("queue_drained", i == 0 ? q0.size() : q1.size(), 0);
    chk("busy_r_idle", busy_r[i], 0);
  endtask

  initial begin
    int n, b0, dw0, dr0, nbusy, np, t1, tl;
    vt[0] = '{0, 0, 16'd1};
    vt[1] = '{0, 1, 16'd2};
    vt[2] = '{0, 2, 16'd3};
    vt[3] = '{0, 511, 16'd512};
    vt[4] = '{0, 1023, 16'd1024};
    vt[5] = '{1, 0, 16'hFFFE};
    vt[6] = '{1, 1, 16'hFFFF};
    vt[7] = '{1, 2, 16'h0000};
    vt[8] = '{1, 3, 16'h0001};
    vt[9] = '{1, 1023, 16'h03FD};
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_outputs", {valid[i], busy_w[i], busy_r[i], done_w[i], done_r[i]}, 0);
      chk("rst_data", {raddr[i], dout[i]}, 0);
    end
    rst = 1'b0;
    tick();
    run_write(0);
    run_read(0);
    run_write(1);
    run_read(1);
    // concurrent write/read with ignored restarts at cycle 100 of each
    push_exp(0);
    b0 = beats[0]; dw0 = done_w_cnt[0]; dr0 = done_r_cnt[0]; nbusy = 0;
    for (int t = 0; t < 1100; t++) begin
      start_w[0] = (t == 0 || t == 100);
      start_r[0] = (t == 2 || t == 102);
      tick();
      if (busy_w[0]) nbusy++;
    end
    start_w[0] = 1'b0;
    start_r[0] = 1'b0;
    chk("conc_busy_w_len", nbusy, 513);
    chk("conc_done_w", done_w_cnt[0] - dw0, 1);
    chk("conc_beats", beats[0] - b0, 1024);
    chk("conc_done_r", done_r_cnt[0] - dr0, 1);
    chk("conc_queue", q0.size(), 0);
    // reset in the middle of a read
    push_exp(0);
    b0 = beats[0];
    start_r[0] = 1'b1;
    tick();
    start_r[0] = 1'b0;
    n = 0;
    while (!(valid[0] && raddr[0] == 10'd300) && n < 1200) begin
      n++;
      tick();
    end
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", valid[0], 0);
    chk("rst_mid_busy_r", busy_r[0], 0);
    chk("rst_mid_data", {raddr[0], dout[0]}, 0);
    chk("rst_mid_beats", beats[0] - b0, 300);
    q0.delete();
    dr0 = done_r_cnt[0];
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("rst_mid_no_done", done_r_cnt[0] - dr0, 0);
    run_read(0);
    // start_w held high: back-to-back write runs, 513 busy cycles plus one idle cycle each
    np = 0; t1 = 0; tl = 0;
    start_w[1] = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      tick();
      if (done_w[1]) begin
        if (np == 0) t1 = t;
        tl = t;
        np++;
      end
    end
    start_w[1] = 1'b0;
    chk("held_done_w_count", np, 3);
    chk("held_first_done", t1, 512);
    chk("held_period", tl - t1, 2 * PERIOD_W);
    n = 0;
    while (busy_w[1] && n < 600) begin
      n++;
      tick();
    end
    chk("held_released_idle", busy_w[1], 0);
    run_read(1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("table_%0d_n%0d", vt[k].inst, vt[k].n),
          vt[k].inst == 0 ? cap0[vt[k].n] : cap1[vt[k].n], vt[k].exp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
